// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - LC-3 sequencer states, opcodes, mux select codes and control word
// Shared by the sequencer and the datapath mux decoders.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_HALT,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR0,
    S_BR1,
    S_JMP,
    S_JSR0,
    S_JSR1,
    S_LEA,
    S_LD0,
    S_LDR0,
    S_LD1,
    S_LD2,
    S_ST0,
    S_STR0,
    S_ST1,
    S_ST2
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ADDR2_OFF11 = 2'b00;
  localparam logic [1:0] ADDR2_OFF9  = 2'b01;
  localparam logic [1:0] ADDR2_OFF6  = 2'b10;
  localparam logic [1:0] ADDR2_ZERO  = 2'b11;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_pc;
    logic       ld_reg;
    logic       ld_cc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       mdrmux;
    logic [1:0] aluk;
  } ctrl_t;

  // Unknown opcodes execute as a NOP, so they resume wherever an instruction end would go.
  function automatic state_t dispatch(input logic [3:0] op, input state_t nop_next);
    case (op)
      OP_ADD:  return S_ADD;
      OP_AND:  return S_AND;
      OP_NOT:  return S_NOT;
      OP_BR:   return S_BR0;
      OP_JMP:  return S_JMP;
      OP_JSR:  return S_JSR0;
      OP_LEA:  return S_LEA;
      OP_LD:   return S_LD0;
      OP_LDR:  return S_LDR0;
      OP_ST:   return S_ST0;
      OP_STR:  return S_STR0;
      default: return nop_next;
    endcase
  endfunction

endpackage

// File: rtl/lc3_isdu_decode.sv
// rtl/lc3_isdu_decode.sv - state to datapath control word decode
// Pure Moore decode except LD_MDR in read states, which follows mem_ready.
module lc3_isdu_decode
  import lc3_ctrl_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH1: begin
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.ld_mar  = 1'b1;
        ctrl_o.ld_pc   = 1'b1;
        ctrl_o.pcmux   = PCMUX_INC;
      end
      S_FETCH2, S_LD1: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mdrmux  = 1'b1;
        ctrl_o.ld_mdr  = mem_ready_i;
      end
      S_FETCH3: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_ir    = 1'b1;
      end
      S_ADD: begin
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.aluk     = ALUK_ADD;
      end
      S_AND: begin
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.aluk     = ALUK_AND;
      end
      S_NOT: begin
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
        ctrl_o.aluk     = ALUK_NOT;
      end
      S_BR1: begin
        ctrl_o.addr1mux = 1'b0;
        ctrl_o.addr2mux = ADDR2_OFF9;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.ld_pc    = 1'b1;
      end
      S_JMP: begin
        ctrl_o.addr1mux = 1'b1;
        ctrl_o.addr2mux = ADDR2_ZERO;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.ld_pc    = 1'b1;
      end
      S_JSR0: begin
        ctrl_o.gate_pc = 1'b1;
        ctrl_o.drmux   = 1'b1;
        ctrl_o.ld_reg  = 1'b1;
      end
      S_JSR1: begin
        ctrl_o.addr1mux = 1'b0;
        ctrl_o.addr2mux = ADDR2_OFF11;
        ctrl_o.pcmux    = PCMUX_ADDER;
        ctrl_o.ld_pc    = 1'b1;
      end
      S_LEA: begin
        ctrl_o.addr2mux    = ADDR2_OFF9;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_reg      = 1'b1;
        ctrl_o.ld_cc       = 1'b1;
      end
      S_LD0, S_ST0: begin
        ctrl_o.addr2mux    = ADDR2_OFF9;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_mar      = 1'b1;
      end
      S_LDR0, S_STR0: begin
        ctrl_o.addr1mux    = 1'b1;
        ctrl_o.addr2mux    = ADDR2_OFF6;
        ctrl_o.gate_marmux = 1'b1;
        ctrl_o.ld_mar      = 1'b1;
      end
      S_LD2: begin
        ctrl_o.gate_mdr = 1'b1;
        ctrl_o.ld_reg   = 1'b1;
        ctrl_o.ld_cc    = 1'b1;
      end
      // Store data reaches MDR through the ALU passing SR (IR[11:9]) onto the bus.
      S_ST1: begin
        ctrl_o.sr1mux   = 1'b1;
        ctrl_o.aluk     = ALUK_PASSA;
        ctrl_o.gate_alu = 1'b1;
        ctrl_o.ld_mdr   = 1'b1;
        ctrl_o.mdrmux   = 1'b0;
      end
      S_ST2: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_isdu_seq.sv
// rtl/lc3_isdu_seq.sv - LC-3 fetch/decode/execute sequencer with SRAM handshake
// Holds the state register and next-state logic; outputs come from lc3_isdu_decode.
module lc3_isdu_seq
  import lc3_ctrl_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_PC,
  output logic       LD_REG,
  output logic       LD_CC,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       MDRMUX,
  output logic [1:0] ALUK
);

  state_t state_q, state_d;
  state_t end_state;
  ctrl_t  ctrl;

  // IR_5 steers SR2MUX in the datapath directly; the sequencer never branches on it.
  logic unused_ir5;
  assign unused_ir5 = IR_5;

  always_comb begin
    end_state = Run ? S_FETCH1 : S_HALT;
    state_d   = state_q;
    case (state_q)
      S_HALT:   state_d = Run ? S_FETCH1 : S_HALT;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = mem_ready ? S_FETCH3 : S_FETCH2;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: state_d = dispatch(Opcode, end_state);
      S_BR0:    state_d = BEN ? S_BR1 : end_state;
      S_JSR0:   state_d = S_JSR1;
      S_LD0,
      S_LDR0:   state_d = S_LD1;
      S_LD1:    state_d = mem_ready ? S_LD2 : S_LD1;
      S_ST0,
      S_STR0:   state_d = S_ST1;
      S_ST1:    state_d = S_ST2;
      S_ST2:    state_d = mem_ready ? end_state : S_ST2;
      S_ADD, S_AND, S_NOT, S_BR1, S_JMP, S_JSR1, S_LEA, S_LD2:
                state_d = end_state;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALT;
    end else begin
      state_q <= state_d;
    end
  end

  lc3_isdu_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign LD_MAR     = ctrl.ld_mar;
  assign LD_MDR     = ctrl.ld_mdr;
  assign LD_IR      = ctrl.ld_ir;
  assign LD_PC      = ctrl.ld_pc;
  assign LD_REG     = ctrl.ld_reg;
  assign LD_CC      = ctrl.ld_cc;
  assign GatePC     = ctrl.gate_pc;
  assign GateMDR    = ctrl.gate_mdr;
  assign GateALU    = ctrl.gate_alu;
  assign GateMARMUX = ctrl.gate_marmux;
  assign ADDR1MUX   = ctrl.addr1mux;
  assign ADDR2MUX   = ctrl.addr2mux;
  assign PCMUX      = ctrl.pcmux;
  assign DRMUX      = ctrl.drmux;
  assign SR1MUX     = ctrl.sr1mux;
  assign MDRMUX     = ctrl.mdrmux;
  assign ALUK       = ctrl.aluk;

endmodule

// File: doc/lc3_isdu_seq.md
# lc3_isdu_seq

Instruction-sequencing controller for the 16-bit LC-3 datapath. It runs the fetch/decode/execute loop and drives every datapath control line: register load enables, bus gates, the ADDR1/ADDR2 effective-address mux selects, PCMUX, DRMUX/SR1MUX and ALUK. It also runs a request/ready handshake to SRAM. It sits between the top level (Run switch, memory port) and the datapath.

## Interface
- No parameters.
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Run  in  1  level; 1 = execute, 0 = halt at next instruction boundary
- Opcode  in  4  IR[15:12]
- IR_5  in  1  immediate select for ADD/AND
- BEN  in  1  branch-enable from datapath nzp logic
- mem_ready  in  1  memory completes access this cycle
- mem_req / mem_we  out  1 each  memory request, 1 = write
- LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle
- ADDR1MUX  out  1  0 = PC, 1 = SR1 out
- ADDR2MUX  out  2  00 = SEXT(IR[10:0]), 01 = SEXT(IR[8:0]), 10 = SEXT(IR[5:0]), 11 = 0
- PCMUX  out  2  00 = PC+1, 01 = bus, 10 = address adder
- DRMUX  out  1  0 = IR[11:9], 1 = R7
- SR1MUX  out  1  0 = IR[8:6], 1 = IR[11:9]
- MDRMUX  out  1  0 = bus, 1 = memory data
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS A

## Operation
- Moore FSM. All outputs are decoded from state only, except LD_MDR in the memory-read states, which is qualified by mem_ready.
- Any output not listed for a state is 0. Mux selects are 0 unless listed.
- HALT: all outputs 0. Go to FETCH1 when Run=1.
- FETCH1: GatePC, LD_MAR, LD_PC, PCMUX=00. Go to FETCH2.
- FETCH2: mem_req=1, MDRMUX=1, LD_MDR=mem_ready. Hold until mem_ready, then go to FETCH3.
- FETCH3: GateMDR, LD_IR. Go to DECODE.
- DECODE: no outputs. Branch on Opcode: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR0, 1100 JMP, 0100 JSR0, 1110 LEA, 0010 LD0, 0110 LDR0, 0011 ST0, 0111 STR0. Any other opcode is a NOP and ends the instruction.
- ADD/AND: GateALU, LD_REG, LD_CC. ALUK=00 (ADD) or 01 (AND). IR_5 is forwarded to the datapath's SR2MUX and not consumed here.
- NOT: GateALU, LD_REG, LD_CC, ALUK=10.
- BR0: if BEN go to BR1, else end. BR1: ADDR1MUX=0, ADDR2MUX=01, PCMUX=10, LD_PC.
- JMP: ADDR1MUX=1, ADDR2MUX=11, PCMUX=10, LD_PC.
- JSR0: GatePC, DRMUX=1, LD_REG. JSR1: ADDR1MUX=0, ADDR2MUX=00, PCMUX=10, LD_PC.
- LEA: ADDR2MUX=01, GateMARMUX, LD_REG, LD_CC.
- LD0: ADDR2MUX=01, GateMARMUX, LD_MAR. Go to LD1.
- LDR0: ADDR1MUX=1, ADDR2MUX=10, GateMARMUX, LD_MAR. Go to LD1.
- LD1: same as FETCH2. Go to LD2 on mem_ready.
- LD2: GateMDR, LD_REG, LD_CC.
- ST0: as LD0, then go to ST1. STR0: as LDR0, then go to ST1.
- ST1: SR1MUX=1, ALUK=11, GateALU, LD_MDR, MDRMUX=0. Go to ST2.
- ST2: mem_req=1, mem_we=1. Hold until mem_ready.
- Instruction end is the last state of each flow (ST2 ends on mem_ready). The next state is FETCH1 if Run=1, else HALT.

## Timing
- After Reset: state HALT, all outputs 0 in the following cycle. Reset overrides everything, including a pending memory access. mem_req drops in the cycle after Reset is sampled.
- Reset during a memory wait abandons the access. No completion is expected.
- Fastest instruction (ADD): FETCH1, FETCH2 with mem_ready=1, FETCH3, DECODE, ADD = 5 cycles. Each memory wait cycle adds 1.
- mem_req stays high and mem_we stable from the first cycle of the access state until the mem_ready cycle inclusive.
- mem_ready outside FETCH2/LD1/ST2 is ignored.
- Run=0 mid-instruction: the instruction completes, then HALT. Run is sampled only at instruction end and in HALT.

## Structure
- Package lc3_ctrl_pkg holds:
  - the state enum;
  - opcode constants;
  - ADDR2/PCMUX/ALUK select constants.
- The ADDR2 constants are shared with the datapath muxes.
- Sub-module lc3_isdu_decode: combinational state-to-control-word decode. The top holds the state register and next-state logic.

## Test plan
- Reset with Run=1 -> next cycle HALT, all outputs 0. Release -> FETCH1 with GatePC=LD_MAR=LD_PC=1.
- ADD (0001), mem_ready immediate -> LD_IR in cycle 3, GateALU+LD_REG+LD_CC in cycle 5, FETCH1 in cycle 6.
- LDR with 3 wait cycles in LD1 -> ADDR1MUX=1 and ADDR2MUX=10 in LDR0; mem_req high 4 cycles; LD_MDR only on the ready cycle.
- BR (0000) with BEN=0 -> no LD_PC after FETCH1. With BEN=1 -> BR1 drives ADDR2MUX=01, PCMUX=10, LD_PC=1.
- JSR -> JSR0 has DRMUX=1 and LD_REG; JSR1 has ADDR2MUX=00 and PCMUX=10. JMP -> ADDR2MUX=11, ADDR1MUX=1.
- STR, Run dropped during ST2, Reset asserted mid-LD1 on a later run -> STR returns to HALT after mem_ready; the Reset cycle leads to HALT with mem_req=0.
